// File: rtl/dual_port_mem_arbiter.sv
// Two-requester round-robin front end for a single pipelined memory port.
// Reads that hit an in-flight write are held off until that write has committed.
module dual_port_mem_arbiter #(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int WRITE_LATENCY = 4,
    parameter int READ_LATENCY  = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [1:0]              i_req_vld,
    input  logic [1:0]              i_req_we,
    input  logic [2*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [2*WIDTH-1:0]      i_req_din,
    output logic [1:0]              o_req_rdy,
    output logic [1:0]              o_rsp_vld,
    output logic [2*WIDTH-1:0]      o_rsp_dout,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [WIDTH-1:0]        o_mem_din,
    input  logic [WIDTH-1:0]        i_mem_dout
);

    logic [1:0]            blk;
    logic [1:0]            elig;
    logic [1:0]            gnt;
    logic                  acc;
    logic                  gsel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_din;
    logic                  prio_q, prio_d;

    logic [WRITE_LATENCY-1:0] wr_v_q;
    logic [ADDR_WIDTH-1:0]    wr_a_q [WRITE_LATENCY];
    logic [READ_LATENCY:0]    rd_v_q;
    logic [READ_LATENCY:0]    rd_id_q;

    logic                  mem_en_q, mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_din_q;
    logic [1:0]            rsp_vld_q;
    logic [2*WIDTH-1:0]    rsp_dout_q;

    // A write is never blocked; a read waits while its address is in the write window.
    always_comb begin
        blk = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < WRITE_LATENCY; k++) begin
                if (wr_v_q[k] && (wr_a_q[k] == i_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    blk[i] = 1'b1;
                end
            end
        end
        elig = i_req_vld & (i_req_we | ~blk);
    end

    always_comb begin
        gnt = '0;
        if (i_rst_n) begin
            if (elig[prio_q]) begin
                gnt[prio_q] = 1'b1;
            end else if (elig[~prio_q]) begin
                gnt[~prio_q] = 1'b1;
            end
        end
    end

    assign acc      = |gnt;
    assign gsel     = gnt[1];
    assign sel_we   = i_req_we[gsel];
    assign sel_addr = gsel ? i_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_req_addr[ADDR_WIDTH-1:0];
    assign sel_din  = gsel ? i_req_din[2*WIDTH-1:WIDTH] : i_req_din[WIDTH-1:0];
    assign prio_d   = acc ? ~gsel : prio_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prio_q     <= 1'b0;
            wr_v_q     <= '0;
            for (int k = 0; k < WRITE_LATENCY; k++) begin
                wr_a_q[k] <= '0;
            end
            rd_v_q     <= '0;
            rd_id_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_dout_q <= '0;
        end else begin
            prio_q   <= prio_d;
            mem_en_q <= acc;
            mem_we_q <= acc & sel_we;
            if (acc) begin
                mem_addr_q <= sel_addr;
                mem_din_q  <= sel_din;
            end

            wr_v_q[0] <= acc & sel_we;
            wr_a_q[0] <= sel_addr;
            for (int k = 1; k < WRITE_LATENCY; k++) begin
                wr_v_q[k] <= wr_v_q[k-1];
                wr_a_q[k] <= wr_a_q[k-1];
            end

            rd_v_q  <= {rd_v_q[READ_LATENCY-1:0], acc & ~sel_we};
            rd_id_q <= {rd_id_q[READ_LATENCY-1:0], gsel};

            // Last tracker stage lines up with the cycle i_mem_dout is valid.
            rsp_vld_q <= '0;
            if (rd_v_q[READ_LATENCY]) begin
                if (rd_id_q[READ_LATENCY]) begin
                    rsp_vld_q[1]                <= 1'b1;
                    rsp_dout_q[2*WIDTH-1:WIDTH] <= i_mem_dout;
                end else begin
                    rsp_vld_q[0]          <= 1'b1;
                    rsp_dout_q[WIDTH-1:0] <= i_mem_dout;
                end
            end
        end
    end

    assign o_req_rdy  = gnt;
    assign o_rsp_vld  = rsp_vld_q;
    assign o_rsp_dout = rsp_dout_q;
    assign o_mem_en   = mem_en_q;
    assign o_mem_we   = mem_we_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_din  = mem_din_q;

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Directed bench for dual_port_mem_arbiter with a pipelined memory model and a response scoreboard.
module tb_dual_port_mem_arbiter;
    localparam int W  = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    vld = '0, we = '0;
    logic [2*AW-1:0] addr = '0;
    logic [2*W-1:0]  din = '0;
    logic [1:0]    rdy, rsp_vld;
    logic [2*W-1:0] rsp_dout;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din, mem_dout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t q[$];

    dual_port_mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .WRITE_LATENCY(4), .READ_LATENCY(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_vld(vld), .i_req_we(we), .i_req_addr(addr),
        .i_req_din(din), .o_req_rdy(rdy), .o_rsp_vld(rsp_vld), .o_rsp_dout(rsp_dout),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: write commits 4 cycles after issue, read data valid 5 cycles after issue.
    logic [W-1:0]  mem [32];
    logic [W-1:0]  rdp [5];
    logic          wqv [4];
    logic [AW-1:0] wqa [4];
    logic [W-1:0]  wqd [4];
    assign mem_dout = rdp[4];

    always @(posedge clk) begin
        if (wqv[3]) mem[wqa[3]] = wqd[3];
        for (int k = 3; k > 0; k--) begin
            wqv[k] <= wqv[k-1];
            wqa[k] <= wqa[k-1];
            wqd[k] <= wqd[k-1];
        end
        wqv[0] <= mem_en & mem_we;
        wqa[0] <= mem_addr;
        wqd[0] <= mem_din;
        for (int k = 4; k > 0; k--) rdp[k] <= rdp[k-1];
        rdp[0] <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic id, input logic [7:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        e.cyc = cyc + 7;
        q.push_back(e);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Scoreboard monitor.
    logic [7:0] last0 = '0, last1 = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last0 = '0;
            last1 = '0;
        end else if (rsp_vld != 2'b00) begin
            if (rsp_vld == 2'b11) begin
                chk("rsp_onehot", {30'd0, rsp_vld}, 32'h1);
            end else if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%0h required=none (cycle %0d)", rsp_vld, cyc);
            end else begin
                e = q.pop_front();
                chk("rsp_id", {30'd0, rsp_vld}, e.id ? 32'h2 : 32'h1);
                chk("rsp_cycle", cyc, e.cyc);
                if (e.id) begin
                    chk("rsp_data1", {24'd0, rsp_dout[15:8]}, {24'd0, e.data});
                    chk("rsp_hold0", {24'd0, rsp_dout[7:0]}, {24'd0, last0});
                    last1 = e.data;
                end else begin
                    chk("rsp_data0", {24'd0, rsp_dout[7:0]}, {24'd0, e.data});
                    chk("rsp_hold1", {24'd0, rsp_dout[15:8]}, {24'd0, last1});
                    last0 = e.data;
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 32; a++) mem[a] = 8'(a + 8'h40);
        mem[5] = 8'h3C;
        mem[7] = 8'h77;
        mem[3] = 8'h11;
        mem[9] = 8'h22;
        for (int k = 0; k < 4; k++) begin
            wqv[k] = 1'b0;
            wqa[k] = '0;
            wqd[k] = '0;
        end
        for (int k = 0; k < 5; k++) rdp[k] = '0;

        // Reset, then contention from release: both read continuously.
        repeat (2) nxt();
        vld = 2'b11; we = 2'b00; addr = {5'd7, 5'd5};
        #1;
        chk("rst_rdy", {30'd0, rdy}, 32'h0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'h0);
        chk("rst_rsp_vld", {30'd0, rsp_vld}, 32'h0);
        chk("rst_rsp_dout", {16'd0, rsp_dout}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("cont_rdy0", {30'd0, rdy}, 32'h1);
        push(1'b0, 8'h3C);
        for (int i = 1; i < 6; i++) begin
            nxt();
            #1;
            chk("cont_rdy", {30'd0, rdy}, (i % 2 == 1) ? 32'h2 : 32'h1);
            chk("cont_mem_en", {31'd0, mem_en}, 32'h1);
            chk("cont_mem_addr", {27'd0, mem_addr}, (i % 2 == 1) ? 32'd5 : 32'd7);
            push((i % 2) == 1, (i % 2 == 1) ? 8'h77 : 8'h3C);
        end
        nxt();
        vld = 2'b00;
        #1;
        chk("cont_last_addr", {27'd0, mem_addr}, 32'd7);
        repeat (10) nxt();

        // Single read of addr 5 by requester 0.
        vld = 2'b01; we = 2'b00; addr = {5'd0, 5'd5};
        #1;
        chk("single_rdy", {30'd0, rdy}, 32'h1);
        push(1'b0, 8'h3C);
        nxt();
        vld = 2'b00;
        #1;
        chk("single_mem_en", {31'd0, mem_en}, 32'h1);
        chk("single_mem_we", {31'd0, mem_we}, 32'h0);
        chk("single_mem_addr", {27'd0, mem_addr}, 32'd5);
        nxt();
        #1;
        chk("idle_mem_en", {31'd0, mem_en}, 32'h0);
        repeat (10) nxt();
        #1;
        chk("hold_dout0", {24'd0, rsp_dout[7:0]}, 32'h3C);
        chk("idle_rsp_vld", {30'd0, rsp_vld}, 32'h0);

        // RAW: req0 writes A5 to addr 3, req1 reads addr 3 from next cycle.
        vld = 2'b01; we = 2'b01; addr = {5'd0, 5'd3}; din = {8'h00, 8'hA5};
        #1;
        chk("raw_wr_rdy", {30'd0, rdy}, 32'h1);
        nxt();
        vld = 2'b10; we = 2'b00; addr = {5'd3, 5'd3};
        #1;
        chk("raw_mem_we", {31'd0, mem_we}, 32'h1);
        chk("raw_mem_addr", {27'd0, mem_addr}, 32'd3);
        chk("raw_mem_din", {24'd0, mem_din}, 32'hA5);
        chk("raw_blocked", {30'd0, rdy}, 32'h0);
        for (int i = 2; i < 5; i++) begin
            nxt();
            #1;
            chk("raw_blocked", {30'd0, rdy}, 32'h0);
        end
        nxt();
        #1;
        chk("raw_unblock", {30'd0, rdy}, 32'h2);
        push(1'b1, 8'hA5);
        nxt();
        vld = 2'b00;
        repeat (10) nxt();

        // Isolation: req0 blocked on addr 9 while req1 reads addr 7.
        vld = 2'b01; we = 2'b01; addr = {5'd0, 5'd9}; din = {8'h00, 8'h5A};
        #1;
        chk("iso_wr_rdy", {30'd0, rdy}, 32'h1);
        nxt();
        vld = 2'b11; we = 2'b00; addr = {5'd7, 5'd9};
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("iso_rdy", {30'd0, rdy}, 32'h2);
            push(1'b1, 8'h77);
            nxt();
        end
        #1;
        chk("iso_release", {30'd0, rdy}, 32'h1);
        push(1'b0, 8'h5A);
        nxt();
        vld = 2'b00;
        repeat (10) nxt();

        // Reset mid-flight: req1 read accepted, reset during cycles T+2..T+3.
        vld = 2'b10; we = 2'b00; addr = {5'd7, 5'd5};
        #1;
        chk("mid_rdy", {30'd0, rdy}, 32'h2);
        nxt();
        vld = 2'b00;
        nxt();
        rst_n = 1'b0;
        vld = 2'b11;
        #1;
        chk("mid_rst_mem_en", {31'd0, mem_en}, 32'h0);
        chk("mid_rst_rsp_vld", {30'd0, rsp_vld}, 32'h0);
        chk("mid_rst_dout", {16'd0, rsp_dout}, 32'h0);
        chk("mid_rst_rdy", {30'd0, rdy}, 32'h0);
        nxt();
        nxt();
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", {30'd0, rdy}, 32'h1);
        push(1'b0, 8'h3C);
        nxt();
        vld = 2'b00;
        repeat (20) nxt();

        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dual_port_mem_arbiter.md
DUAL_PORT_MEM_ARBITER -- requirements
Module: dual_port_mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of requests and responses.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, memory address width.
REQ-003 SHALL have parameter WRITE_LATENCY, default 4, cycles from memory write issue to commit.
REQ-004 SHALL have parameter READ_LATENCY, default 5, cycles from memory read issue to valid i_mem_dout.
REQ-005 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port i_req_vld, input, 2, per-requester request valid (bit i = requester i).
REQ-008 SHALL have port i_req_we, input, 2, per-requester write enable (1 write, 0 read).
REQ-009 SHALL have port i_req_addr, input, 2*ADDR_WIDTH, requester i address in slice i.
REQ-010 SHALL have port i_req_din, input, 2*WIDTH, requester i write data in slice i.
REQ-011 SHALL have port o_req_rdy, output, 2, per-requester accept strobe.
REQ-012 SHALL have port o_rsp_vld, output, 2, per-requester read-response valid.
REQ-013 SHALL have port o_rsp_dout, output, 2*WIDTH, read data for requester i in slice i.
REQ-014 SHALL have ports o_mem_en, o_mem_we (output, 1), o_mem_addr (output, ADDR_WIDTH), o_mem_din (output, WIDTH), i_mem_dout (input, WIDTH): one memory port.

Function
REQ-015 SHALL accept request i in cycle T when i_req_vld[i] and o_req_rdy[i] are both high; o_req_rdy is combinational in T.
REQ-016 SHALL assert at most one o_req_rdy bit per cycle.
REQ-017 SHALL treat requester i as eligible when i_req_vld[i]=1 and it is not hazard-blocked (REQ-020).
REQ-018 SHALL arbitrate round-robin among eligible requesters: priority goes to the requester not granted last; the pointer advances only on a grant; after reset, requester 0 has priority.
REQ-019 SHALL drive a request accepted in T onto o_mem_en=1, o_mem_we, o_mem_addr, o_mem_din in T+1 (registered); o_mem_en=0 and o_mem_we=0 in cycles with no acceptance.
REQ-020 SHALL hazard-block a read whose address equals that of any write accepted in cycles T-WRITE_LATENCY..T-1; earliest accept of that read is T_write+WRITE_LATENCY+1.
REQ-021 SHALL track in-flight writes in a WRITE_LATENCY-deep {valid, addr} shift structure; writes are never blocked.
REQ-022 SHALL track in-flight reads in a READ_LATENCY+1-deep {valid, id} shift structure, one entry per cycle, with no back-pressure.
REQ-023 SHALL capture i_mem_dout READ_LATENCY cycles after the o_mem_en cycle; it SHALL assert o_rsp_vld[id] for one cycle with the data in slice id, at accept+READ_LATENCY+2.
REQ-024 SHALL return responses in issue order; o_rsp_vld SHALL never have both bits set.
REQ-025 SHALL not let a hazard-blocked requester stall the other requester.
REQ-026 SHALL hold o_rsp_dout slices at their last value when the matching o_rsp_vld bit is low.

Reset
REQ-027 SHALL on i_rst_n low immediately force all registered outputs (o_mem_*, o_rsp_vld, o_rsp_dout) to 0, clear both trackers and set priority to requester 0.
REQ-028 SHALL drop reads in flight at reset; no o_rsp_vld SHALL follow from them.
REQ-029 SHALL hold o_req_rdy at 0 while i_rst_n is low and SHALL resume arbitration on the first rising edge after release.

Verification
REQ-030 Single read: req0 reads addr 5 (mem[5]=0x3C) at T -> o_req_rdy=01 in T; o_mem_en=1, we=0, addr=5 in T+1; o_rsp_vld=01 with dout 0x3C in T+7.
REQ-031 Contention: both requesters hold reads continuously from reset -> grants 0,1,0,1...; 1 accept per cycle; responses alternate in the same order.
REQ-032 RAW hazard: req0 writes 0xA5 to addr 3 at T; req1 reads addr 3 from T -> o_req_rdy[1]=0 through T+4, accepted T+5, o_rsp_dout slice1=0xA5 at T+12.
REQ-033 Hazard isolation: req0 blocked reading addr 3 under REQ-020 while req1 reads addr 7 -> req1 granted every cycle until req0 unblocks.
REQ-034 Reset mid-flight: read accepted at T, i_rst_n low T+2..T+3 -> outputs 0 immediately; no o_rsp_vld through T+20; next request after release accepted by requester 0 first.
